ps2_key_sequencer: RTL
======================

# ps2_key_sequencer

- Sits between the PS/2 receiver's ASCII FIFO and the CPU-side key register.
- Pops bytes from the FIFO and collapses the make/break byte stream into single key events.
- Times out orphaned break prefixes and counts them.
- Presents each event on a valid/ready handshake, back-pressuring the FIFO while an event is pending.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000000: clk cycles allowed between a 0xF0 break prefix and its key byte.
- TMR_W, 20: timer width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO head byte; valid whenever fifo_empty=0 (first-word-fall-through).
- fifo_rd  out  1  one-cycle pop strobe; never asserted while fifo_empty=1.
- key_valid  out  1  key event available.
- key_ready  in  1  consumer accepts the event.
- key_code  out  8  ASCII code of the event.
- key_release  out  1  1 = release event, 0 = press event.
- drop_cnt  out  8  saturating count of timed-out break prefixes.
- busy  out  1  high in any state other than IDLE.

## Operation
- Byte 0xF0 is the break prefix. Byte 0x23 ('#', unmapped key) is forwarded like any other code.
- States: IDLE, DECODE, BRK_WAIT, BRK_DEC, OUT.
- IDLE:
  - If fifo_empty=0: assert fifo_rd combinationally, latch fifo_data into byte_r, go to DECODE.
  - Otherwise stay in IDLE.
- DECODE:
  - byte_r==0xF0: clear timer, go to BRK_WAIT.
  - Any other byte: key_code<=byte_r, key_release<=0, go to OUT.
- BRK_WAIT:
  - If fifo_empty=0: pop, latch into byte_r, go to BRK_DEC.
  - Else if timer==TIMEOUT_CYCLES-1: drop_cnt<=drop_cnt+1 (saturate at 255), go to IDLE.
  - Else timer<=timer+1.
  - If a byte arrives in the same cycle the timer expires, the byte wins.
- BRK_DEC:
  - byte_r==0xF0 (repeated prefix): clear timer, go back to BRK_WAIT.
  - Otherwise release handling per Configuration.
- OUT:
  - key_valid=1.
  - key_code and key_release stay stable until key_valid&key_ready is sampled at a rising edge; then go to IDLE.
  - No FIFO pops occur in OUT.
- Reset: all state cleared and the machine goes to IDLE. An in-flight byte or pending event is discarded; the FIFO is not popped during the reset cycle.

## Timing
- Reset values: fifo_rd=0, key_valid=0, key_code=0x00, key_release=0, drop_cnt=0, busy=0.
- Press latency: head byte available in IDLE at cycle t gives fifo_rd at t, DECODE at t+1, key_valid=1 from t+2.
- Release latency:
  - 0xF0 popped at t.
  - Key byte popped at t+2 at the earliest.
  - key_valid from t+4 at the earliest.
- Handshake:
  - key_ready may be high before key_valid; the transfer then completes in the first OUT cycle.
  - key_valid falls the cycle after the transfer.
  - The next fifo_rd occurs no earlier than that following IDLE cycle.
- Throughput: at most one event per 3 cycles with key_ready tied high.
- Timeout: expires exactly TIMEOUT_CYCLES cycles after BRK_WAIT entry if no byte arrives.
- busy is registered from the state; it is high from the cycle after the pop until the return to IDLE.

## Configuration
- BREAK_EVENT_EN defined:
  - BRK_DEC with a non-0xF0 byte loads key_code<=byte_r, key_release<=1, then goes to OUT.
  - Each release produces one event.
- BREAK_EVENT_EN undefined:
  - BRK_DEC with a non-0xF0 byte goes directly to IDLE with no event.
  - key_release is tied to 0.
  - Only press events are emitted; the timeout and drop_cnt behaviour is unchanged.

## Test plan
- Press: FIFO holds 0x41, key_ready=1 → fifo_rd pulse, key_valid two cycles later with key_code=0x41, key_release=0, then one cycle high.
- Release with macro: FIFO 0x41,0xF0,0x41 → press event 0x41/0, then release event 0x41/1; without macro, only 0x41/0 appears.
- Backpressure: key_ready=0 for 20 cycles with FIFO holding 0x31,0x32 → key_code holds 0x31, no fifo_rd during the stall, then 0x32 follows the transfer.
- Timeout: TIMEOUT_CYCLES=16, lone 0xF0 → return to IDLE after 16 cycles, drop_cnt=1, no event; late byte 0x42 then yields press 0x42/0.
- Double prefix and saturation: 0xF0,0xF0,0x43 → one release 0x43/1 (macro defined); 256 timeouts → drop_cnt holds 255.
- Reset mid-OUT: rst pulsed while key_valid=1 → key_valid=0 next cycle, drop_cnt=0, FIFO content untouched.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: pops bytes from the PS/2 receiver's first-word-fall-through
// ASCII FIFO and turns the make/break byte stream into single key events on a
// valid/ready handshake. A 0xF0 break prefix that is not followed by a key byte
// within TIMEOUT_CYCLES is dropped and counted in a saturating drop counter.
// Optional feature macro: BREAK_EVENT_EN. When defined, released keys produce
// events with key_release=1. When undefined, releases are swallowed and only
// press events are emitted.
module ps2_key_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMR_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic [7:0] drop_cnt,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        BRK_WAIT,
        BRK_DEC,
        OUT
    } state_t;

    localparam logic [7:0]       BRK_PREFIX = 8'hF0;
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg;
    logic [7:0]       byte_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [7:0]       key_code_reg;
    logic [7:0]       drop_cnt_reg;
    logic             key_valid_reg;
    logic             busy_reg;
`ifdef BREAK_EVENT_EN
    logic             key_release_reg;
`endif

    // Pop only in the two byte-accepting states, and never while in reset so an
    // in-flight head byte survives a reset untouched.
    assign fifo_rd = !rst && !fifo_empty && ((state_reg == IDLE) || (state_reg == BRK_WAIT));

    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign drop_cnt  = drop_cnt_reg;
    assign busy      = busy_reg;
`ifdef BREAK_EVENT_EN
    assign key_release = key_release_reg;
`else
    assign key_release = 1'b0;
`endif

    // Sequencer state machine with registered outputs; busy and key_valid are
    // updated together with the state so they track it without decode logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            byte_reg      <= 8'h00;
            timer_reg     <= '0;
            key_code_reg  <= 8'h00;
            drop_cnt_reg  <= 8'h00;
            key_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef BREAK_EVENT_EN
            key_release_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        byte_reg  <= fifo_data;
                        state_reg <= DECODE;
                        busy_reg  <= 1'b1;
                    end
                end
                DECODE: begin
                    if (byte_reg == BRK_PREFIX) begin
                        timer_reg <= '0;
                        state_reg <= BRK_WAIT;
                    end else begin
                        key_code_reg  <= byte_reg;
`ifdef BREAK_EVENT_EN
                        key_release_reg <= 1'b0;
`endif
                        key_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end
                end
                BRK_WAIT: begin
                    // An arriving byte takes priority over an expiring timer.
                    if (!fifo_empty) begin
                        byte_reg  <= fifo_data;
                        state_reg <= BRK_DEC;
                    end else if (timer_reg == TMR_LAST) begin
                        if (drop_cnt_reg != 8'hFF) begin
                            drop_cnt_reg <= drop_cnt_reg + 8'd1;
                        end
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                BRK_DEC: begin
                    if (byte_reg == BRK_PREFIX) begin
                        // Repeated prefix restarts the wait window.
                        timer_reg <= '0;
                        state_reg <= BRK_WAIT;
                    end else begin
`ifdef BREAK_EVENT_EN
                        key_code_reg    <= byte_reg;
                        key_release_reg <= 1'b1;
                        key_valid_reg   <= 1'b1;
                        state_reg       <= OUT;
`else
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
`endif
                    end
                end
                OUT: begin
                    if (key_ready) begin
                        key_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    key_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

endmodule
